register_bank_mp: RTL and testbench

REGISTER_BANK_MP -- requirements
Module: register_bank_mp

---
 rtl/register_bank_mp.sv | 79 +++++++
 tb/tb_register_bank_mp.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_bank_mp.sv
// rtl/register_bank_mp.sv - multi-port register bank with busy tracking, dual write and bypass
module register_bank_mp #(
  parameter int INDEX_SIZE = 4,
  parameter int WIDTH      = 32,
  parameter int NUM_READ   = 3,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_READ*INDEX_SIZE-1:0] ra,
  output logic [NUM_READ*WIDTH-1:0]    rd_data,
  output logic [NUM_READ-1:0]          rd_busy,
  input  logic                         we0,
  input  logic [INDEX_SIZE-1:0]        wa0,
  input  logic [WIDTH-1:0]             wd0,
  input  logic                         we1,
  input  logic [INDEX_SIZE-1:0]        wa1,
  input  logic [WIDTH-1:0]             wd1,
  input  logic                         alloc_en,
  input  logic [INDEX_SIZE-1:0]        alloc_idx,
  output logic                         alloc_ok,
  output logic [7:0]                   conflict_cnt
);

  localparam int DEPTH = 1 << INDEX_SIZE;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;

  logic w0_hit, w1_hit, same_addr, alloc_set;

  assign w0_hit    = we0 && (wa0 != '0);
  assign w1_hit    = we1 && (wa1 != '0);
  assign same_addr = w0_hit && w1_hit && (wa0 == wa1);

  // A register being written this cycle frees up, so it may be re-allocated at once.
  assign alloc_ok  = (alloc_idx == '0) || !busy[alloc_idx] ||
                     (w0_hit && wa0 == alloc_idx) || (w1_hit && wa1 == alloc_idx);
  assign alloc_set = alloc_en && alloc_ok && (alloc_idx != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy         <= '0;
      conflict_cnt <= '0;
    end else begin
      if (w0_hit && !same_addr) regs[wa0] <= wd0;
      if (w1_hit)               regs[wa1] <= wd1;
      if (w0_hit)               busy[wa0] <= 1'b0;
      if (w1_hit)               busy[wa1] <= 1'b0;
      // Alloc is applied last so it wins over a same-cycle write clear.
      if (alloc_set)            busy[alloc_idx] <= 1'b1;
      if (same_addr && conflict_cnt != 8'hFF) conflict_cnt <= conflict_cnt + 8'd1;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_READ; k++) begin : read_port
      logic [INDEX_SIZE-1:0] a;
      logic                  fwd0, fwd1;
      a    = ra[k*INDEX_SIZE +: INDEX_SIZE];
      fwd1 = BYPASS && w1_hit && (wa1 == a);
      fwd0 = BYPASS && w0_hit && (wa0 == a);
      if (a == '0) begin
        rd_data[k*WIDTH +: WIDTH] = '0;
        rd_busy[k]                = 1'b0;
      end else begin
        if (fwd1)      rd_data[k*WIDTH +: WIDTH] = wd1;
        else if (fwd0) rd_data[k*WIDTH +: WIDTH] = wd0;
        else           rd_data[k*WIDTH +: WIDTH] = regs[a];
        if ((fwd0 || fwd1) && !(alloc_set && alloc_idx == a)) rd_busy[k] = 1'b0;
        else                                                   rd_busy[k] = busy[a];
      end
    end
  end

endmodule

// File: tb/tb_register_bank_mp.sv
// tb/tb_register_bank_mp.sv - directed self-checking bench for register_bank_mp (bypass and non-bypass)
module tb_register_bank_mp;

  logic        clk;
  logic        rst;
  logic [11:0] ra;
  logic        we0, we1, alloc_en;
  logic [3:0]  wa0, wa1, alloc_idx;
  logic [31:0] wd0, wd1;

  logic [95:0] rd_a, rd_b;
  logic [2:0]  busy_a, busy_b;
  logic        ok_a, ok_b;
  logic [7:0]  cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;

  register_bank_mp #(.INDEX_SIZE(4), .WIDTH(32), .NUM_READ(3), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .ra(ra), .rd_data(rd_a), .rd_busy(busy_a),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .alloc_en(alloc_en), .alloc_idx(alloc_idx), .alloc_ok(ok_a), .conflict_cnt(cnt_a)
  );

  register_bank_mp #(.INDEX_SIZE(4), .WIDTH(32), .NUM_READ(3), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .ra(ra), .rd_data(rd_b), .rd_busy(busy_b),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .alloc_en(alloc_en), .alloc_idx(alloc_idx), .alloc_ok(ok_b), .conflict_cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    alloc_en = 1'b0; alloc_idx = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    ra = {4'd3, 4'd2, 4'd1};
    #2;
    checks++;
    if (rd_a !== 96'h0) begin errors++; $display("FAIL reset_rd_a got %h want 0", rd_a); end
    checks++;
    if (busy_a !== 3'b000 || busy_b !== 3'b000) begin errors++; $display("FAIL reset_busy got %b/%b want 000", busy_a, busy_b); end
    checks++;
    if (ok_a !== 1'b1) begin errors++; $display("FAIL reset_alloc_ok got %b want 1", ok_a); end
    checks++;
    if (cnt_a !== 8'd0 || cnt_b !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d want 0", cnt_a, cnt_b); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    we0 = 1'b1; wa0 = 4'd5; wd0 = 32'hDEADBEEF;
    ra = {4'd0, 4'd0, 4'd5};
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (rd_a[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_r5_bypass got %h want deadbeef", rd_a[31:0]); end
    checks++;
    if (rd_b[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_r5_nobypass got %h want deadbeef", rd_b[31:0]); end
    checks++;
    if (rd_a[63:32] !== 32'h0) begin errors++; $display("FAIL rd_r0 got %h want 0", rd_a[63:32]); end
  endtask

  task automatic test_zero();
    @(negedge clk);
    we0 = 1'b1; wa0 = 4'd0; wd0 = 32'hFFFFFFFF;
    we1 = 1'b1; wa1 = 4'd0; wd1 = 32'h12345678;
    alloc_en = 1'b1; alloc_idx = 4'd0;
    ra = {4'd0, 4'd0, 4'd0};
    #1;
    checks++;
    if (ok_a !== 1'b1) begin errors++; $display("FAIL zero_alloc_ok got %b want 1", ok_a); end
    checks++;
    if (rd_a[31:0] !== 32'h0) begin errors++; $display("FAIL zero_bypass got %h want 0", rd_a[31:0]); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (rd_b[31:0] !== 32'h0 || busy_b[0] !== 1'b0) begin errors++; $display("FAIL zero_after got %h/%b want 0/0", rd_b[31:0], busy_b[0]); end
    checks++;
    if (cnt_a !== 8'd0) begin errors++; $display("FAIL zero_no_conflict got %0d want 0", cnt_a); end
  endtask

  task automatic test_dual_conflict();
    @(negedge clk);
    we0 = 1'b1; wa0 = 4'd7; wd0 = 32'h11;
    we1 = 1'b1; wa1 = 4'd7; wd1 = 32'h22;
    ra = {4'd0, 4'd0, 4'd7};
    #1;
    checks++;
    if (rd_a[31:0] !== 32'h22) begin errors++; $display("FAIL dual_bypass got %h want 22", rd_a[31:0]); end
    @(negedge clk);
    wa0 = 4'd4; wd0 = 32'h44;
    wa1 = 4'd6; wd1 = 32'h66;
    ra = {4'd6, 4'd4, 4'd7};
    #1;
    checks++;
    if (rd_b[31:0] !== 32'h22) begin errors++; $display("FAIL dual_r7 got %h want 22", rd_b[31:0]); end
    checks++;
    if (cnt_a !== 8'd1) begin errors++; $display("FAIL dual_cnt1 got %0d want 1", cnt_a); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (rd_b[63:32] !== 32'h44 || rd_b[95:64] !== 32'h66) begin errors++; $display("FAIL dual_distinct got %h/%h want 44/66", rd_b[63:32], rd_b[95:64]); end
    checks++;
    if (cnt_b !== 8'd1) begin errors++; $display("FAIL distinct_no_cnt got %0d want 1", cnt_b); end
    for (int i = 0; i < 253; i++) begin
      @(negedge clk);
      we0 = 1'b1; wa0 = 4'd7; wd0 = 32'h11;
      we1 = 1'b1; wa1 = 4'd7; wd1 = 32'h22;
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (cnt_a !== 8'd254) begin errors++; $display("FAIL cnt_254 got %0d want 254", cnt_a); end
    @(negedge clk);
    we0 = 1'b1; wa0 = 4'd7; we1 = 1'b1; wa1 = 4'd7;
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (cnt_a !== 8'd255) begin errors++; $display("FAIL cnt_255 got %0d want 255", cnt_a); end
    for (int i = 0; i < 46; i++) begin
      @(negedge clk);
      we0 = 1'b1; wa0 = 4'd7; we1 = 1'b1; wa1 = 4'd7;
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (cnt_a !== 8'd255 || cnt_b !== 8'd255) begin errors++; $display("FAIL cnt_saturate got %0d/%0d want 255", cnt_a, cnt_b); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    we0 = 1'b1; wa0 = 4'd3; wd0 = 32'hA5;
    ra = {4'd0, 4'd0, 4'd3};
    #1;
    checks++;
    if (rd_a[31:0] !== 32'hA5) begin errors++; $display("FAIL bypass_fwd got %h want a5", rd_a[31:0]); end
    checks++;
    if (rd_b[31:0] !== 32'h0) begin errors++; $display("FAIL nobypass_old got %h want 0", rd_b[31:0]); end
    @(negedge clk);
    we0 = 1'b1; wa0 = 4'd3; wd0 = 32'h1;
    we1 = 1'b1; wa1 = 4'd3; wd1 = 32'hB6;
    #1;
    checks++;
    if (rd_a[31:0] !== 32'hB6) begin errors++; $display("FAIL bypass_wd1_wins got %h want b6", rd_a[31:0]); end
    checks++;
    if (rd_b[31:0] !== 32'hA5) begin errors++; $display("FAIL nobypass_after_edge got %h want a5", rd_b[31:0]); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (rd_b[31:0] !== 32'hB6) begin errors++; $display("FAIL nobypass_wd1 got %h want b6", rd_b[31:0]); end
  endtask

  task automatic test_alloc();
    @(negedge clk);
    alloc_en = 1'b1; alloc_idx = 4'd9;
    ra = {4'd0, 4'd0, 4'd9};
    #1;
    checks++;
    if (ok_a !== 1'b1 || busy_a[0] !== 1'b0) begin errors++; $display("FAIL alloc_first got ok=%b busy=%b want 1/0", ok_a, busy_a[0]); end
    @(negedge clk);
    alloc_en = 1'b0;
    #1;
    checks++;
    if (busy_a[0] !== 1'b1 || busy_b[0] !== 1'b1) begin errors++; $display("FAIL alloc_busy got %b/%b want 1/1", busy_a[0], busy_b[0]); end
    checks++;
    if (ok_a !== 1'b0) begin errors++; $display("FAIL alloc_ok_busy got %b want 0", ok_a); end
    @(negedge clk);
    alloc_en = 1'b1;
    #1;
    checks++;
    if (ok_b !== 1'b0) begin errors++; $display("FAIL alloc_refused got %b want 0", ok_b); end
    @(negedge clk);
    alloc_en = 1'b0;
    #1;
    checks++;
    if (busy_a[0] !== 1'b1 || rd_a[31:0] !== 32'h0) begin errors++; $display("FAIL refused_unchanged got busy=%b data=%h want 1/0", busy_a[0], rd_a[31:0]); end
    @(negedge clk);
    we0 = 1'b1; wa0 = 4'd9; wd0 = 32'h5;
    #1;
    checks++;
    if (ok_a !== 1'b1) begin errors++; $display("FAIL alloc_ok_written got %b want 1", ok_a); end
    checks++;
    if (busy_a[0] !== 1'b0 || busy_b[0] !== 1'b1) begin errors++; $display("FAIL busy_bypass got %b/%b want 0/1", busy_a[0], busy_b[0]); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (busy_b[0] !== 1'b0 || rd_b[31:0] !== 32'h5) begin errors++; $display("FAIL write_clears got busy=%b data=%h want 0/5", busy_b[0], rd_b[31:0]); end
    @(negedge clk);
    alloc_en = 1'b1; alloc_idx = 4'd9;
    @(negedge clk);
    we0 = 1'b1; wa0 = 4'd9; wd0 = 32'h5A;
    #1;
    checks++;
    if (ok_a !== 1'b1 || busy_a[0] !== 1'b1) begin errors++; $display("FAIL wr_alloc_comb got ok=%b busy=%b want 1/1", ok_a, busy_a[0]); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (rd_b[31:0] !== 32'h5A || busy_b[0] !== 1'b1) begin errors++; $display("FAIL wr_alloc_edge got data=%h busy=%b want 5a/1", rd_b[31:0], busy_b[0]); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    we0 = 1'b1; wa0 = 4'd2; wd0 = 32'h1234;
    alloc_en = 1'b1; alloc_idx = 4'd2;
    ra = {4'd0, 4'd0, 4'd2};
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (rd_b[31:0] !== 32'h1234 || busy_b[0] !== 1'b1) begin errors++; $display("FAIL pre_reset got data=%h busy=%b want 1234/1", rd_b[31:0], busy_b[0]); end
    @(negedge clk);
    we0 = 1'b1; wa0 = 4'd2; wd0 = 32'h9999;
    alloc_en = 1'b1; alloc_idx = 4'd2;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (rd_b[31:0] !== 32'h0) begin errors++; $display("FAIL reset_async_data got %h want 0", rd_b[31:0]); end
    checks++;
    if (rd_a[31:0] !== 32'h9999) begin errors++; $display("FAIL reset_bypass_fwd got %h want 9999", rd_a[31:0]); end
    checks++;
    if (busy_a[0] !== 1'b0 || busy_b[0] !== 1'b0) begin errors++; $display("FAIL reset_async_busy got %b/%b want 0/0", busy_a[0], busy_b[0]); end
    checks++;
    if (cnt_a !== 8'd0 || ok_a !== 1'b1) begin errors++; $display("FAIL reset_async_cnt_ok got %0d/%b want 0/1", cnt_a, ok_a); end
    @(posedge clk);
    #1;
    checks++;
    if (rd_b[31:0] !== 32'h0 || busy_b[0] !== 1'b0) begin errors++; $display("FAIL reset_no_land got data=%h busy=%b want 0/0", rd_b[31:0], busy_b[0]); end
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (rd_a[31:0] !== 32'h0 || rd_b[31:0] !== 32'h0) begin errors++; $display("FAIL post_reset got %h/%h want 0", rd_a[31:0], rd_b[31:0]); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero();
    test_dual_conflict();
    test_bypass();
    test_alloc();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
